bus_arbiter: RTL and testbench

//  Arbitration and split controller for the 2-master serial system bus. Grants bus ownership to

---
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two bus masters, the bus sequencer and the arbiter.
interface bus_arbiter_if;
    logic       m1_breq;
    logic       m2_breq;
    logic       tx_done;
    logic       s3_split;
    logic       m1_bgrant;
    logic       m2_bgrant;
    logic       m1_split;
    logic       m2_split;
    logic       s3_split_grant;
    logic [1:0] bus_sel;
    logic       bus_busy;
    logic       timeout;

    // Requester side: masters, sequencer and slave 3 drive requests and events.
    modport master (
        output m1_breq, m2_breq, tx_done, s3_split,
        input  m1_bgrant, m2_bgrant, m1_split, m2_split, s3_split_grant, bus_sel, bus_busy,
               timeout
    );

    // Arbiter side.
    modport slave (
        input  m1_breq, m2_breq, tx_done, s3_split,
        output m1_bgrant, m2_bgrant, m1_split, m2_split, s3_split_grant, bus_sel, bus_busy,
               timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with split/resume handling for slave 3.
// Optional feature macro: ARB_TIMEOUT_EN builds a per-grant watchdog that forces release after
// TIMEOUT_CYCLES owned cycles; without it the timeout output is tied low.
module bus_arbiter #(
    parameter int unsigned ARB_MODE       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input logic          clk,
    input logic          rstn,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StOwnM1, StOwnM2, StResume} state_e;

    state_e state_q, state_d;
    logic   m1_split_q, m1_split_d;
    logic   m2_split_q, m2_split_d;
    logic   resume_q, resume_d;
    logic   last_m2_q, last_m2_d;
    logic   m1_bgrant_q, m1_bgrant_d;
    logic   m2_bgrant_q, m2_bgrant_d;
    logic   s3_grant_q, s3_grant_d;
    logic   busy_q, busy_d;
    logic   timeout_q, timeout_d;

    logic own, own_m2, owner_breq, split_pend, split_take, own_end, tmo_hit;
    logic m1_elig, m2_elig, owner_elig, other_elig, e1_end, e2_end;

    // True when M2 should win, given which masters are eligible and who owned last.
    function automatic logic pick_m2(input logic e1, input logic e2, input logic last_m2);
        if (e1 && e2) begin
            return (ARB_MODE == 0) ? 1'b0 : ~last_m2;
        end
        return e2;
    endfunction

    assign own        = (state_q == StOwnM1) || (state_q == StOwnM2);
    assign own_m2     = (state_q == StOwnM2);
    assign owner_breq = own_m2 ? bus.m2_breq : bus.m1_breq;
    assign split_pend = m1_split_q | m2_split_q;
    assign split_take = own & bus.s3_split & ~split_pend;
    assign own_end    = own & (split_take | bus.tx_done | ~owner_breq | tmo_hit);
    assign m1_elig    = bus.m1_breq & ~m1_split_q;
    assign m2_elig    = bus.m2_breq & ~m2_split_q;
    // The owner is never parked; a split or watchdog release removes it from the next choice.
    assign owner_elig = owner_breq & ~split_take & ~tmo_hit;
    assign other_elig = own_m2 ? m1_elig : m2_elig;
    assign e1_end     = own_m2 ? other_elig : owner_elig;
    assign e2_end     = own_m2 ? owner_elig : other_elig;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo_hit = own && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !bus.tx_done &&
                     !split_take && owner_breq;

    // Owned-cycle counter: restarts whenever a grant ends or a new one begins.
    always_comb begin
        cnt_d = (own && !own_end) ? cnt_q + 1'b1 : '0;
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{CNT_W[0], TIMEOUT_CYCLES[0]};
    assign tmo_hit    = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        m1_split_d = m1_split_q;
        m2_split_d = m2_split_q;
        // Slave 3 dropping its split level means the parked master can be resumed.
        resume_d   = resume_q | (split_pend & ~bus.s3_split);
        last_m2_d  = last_m2_q;
        timeout_d  = tmo_hit;

        unique case (state_q)
            StIdle: begin
                if (resume_q) begin
                    state_d = StResume;
                end else if (m1_elig || m2_elig) begin
                    state_d = pick_m2(m1_elig, m2_elig, last_m2_q) ? StOwnM2 : StOwnM1;
                end
            end
            StOwnM1, StOwnM2: begin
                if (own_end) begin
                    last_m2_d = own_m2;
                    if (split_take) begin
                        if (own_m2) m2_split_d = 1'b1;
                        else        m1_split_d = 1'b1;
                    end
                    if (resume_q) begin
                        state_d = StResume;
                    end else if (other_elig) begin
                        state_d = pick_m2(e1_end, e2_end, own_m2) ? StOwnM2 : StOwnM1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StResume: begin
                state_d = m2_bgrant_q ? StOwnM2 : StOwnM1;
            end
            default: state_d = StIdle;
        endcase

        // Entering resume hands the bus to the parked master and clears the split record.
        if (state_d == StResume) begin
            m1_split_d = 1'b0;
            m2_split_d = 1'b0;
            resume_d   = 1'b0;
        end

        m1_bgrant_d = (state_d == StOwnM1) || ((state_d == StResume) && m1_split_q);
        m2_bgrant_d = (state_d == StOwnM2) || ((state_d == StResume) && m2_split_q);
        s3_grant_d  = (state_d == StResume);
        busy_d      = m1_bgrant_d | m2_bgrant_d | s3_grant_d;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            m1_split_q  <= 1'b0;
            m2_split_q  <= 1'b0;
            resume_q    <= 1'b0;
            last_m2_q   <= 1'b1;
            m1_bgrant_q <= 1'b0;
            m2_bgrant_q <= 1'b0;
            s3_grant_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            m1_split_q  <= m1_split_d;
            m2_split_q  <= m2_split_d;
            resume_q    <= resume_d;
            last_m2_q   <= last_m2_d;
            m1_bgrant_q <= m1_bgrant_d;
            m2_bgrant_q <= m2_bgrant_d;
            s3_grant_q  <= s3_grant_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.m1_bgrant      = m1_bgrant_q;
    assign bus.m2_bgrant      = m2_bgrant_q;
    assign bus.m1_split       = m1_split_q;
    assign bus.m2_split       = m2_split_q;
    assign bus.s3_split_grant = s3_grant_q;
    assign bus.bus_sel        = {m2_bgrant_q, m1_bgrant_q};
    assign bus.bus_busy       = busy_q;
    assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin and a fixed-priority instance see the same stimulus and
// are each compared against a transaction-level reference model every cycle.
module tb_bus_arbiter;
    localparam int unsigned T = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic m1_breq = 1'b0, m2_breq = 1'b0, tx_done = 1'b0, s3_split = 1'b0;

    int checks;
    int errors;

    bus_arbiter_if rr_if ();
    bus_arbiter_if fp_if ();

    assign rr_if.m1_breq  = m1_breq;
    assign rr_if.m2_breq  = m2_breq;
    assign rr_if.tx_done  = tx_done;
    assign rr_if.s3_split = s3_split;
    assign fp_if.m1_breq  = m1_breq;
    assign fp_if.m2_breq  = m2_breq;
    assign fp_if.tx_done  = tx_done;
    assign fp_if.s3_split = s3_split;

    bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(T), .CNT_W(4)) u_rr (
        .clk (clk),
        .rstn(rstn),
        .bus (rr_if.slave)
    );

    bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(T), .CNT_W(4)) u_fp (
        .clk (clk),
        .rstn(rstn),
        .bus (fp_if.slave)
    );

    always #5 clk = ~clk;

    // {m1_bgrant, m2_bgrant, m1_split, m2_split, s3_split_grant, bus_sel, bus_busy, timeout}
    wire [8:0] obs_rr = {rr_if.m1_bgrant, rr_if.m2_bgrant, rr_if.m1_split, rr_if.m2_split,
                         rr_if.s3_split_grant, rr_if.bus_sel, rr_if.bus_busy, rr_if.timeout};
    wire [8:0] obs_fp = {fp_if.m1_bgrant, fp_if.m2_bgrant, fp_if.m1_split, fp_if.m2_split,
                         fp_if.s3_split_grant, fp_if.bus_sel, fp_if.bus_busy, fp_if.timeout};

    // Bus view: who holds the bus (0 none), who is parked, whether a resume is owed,
    // who owned last, whether this is the resume cycle, how long the owner has held it.
    typedef struct packed {
        logic [1:0] owner;
        logic [1:0] parked;
        logic       resume;
        logic [1:0] last;
        logic       in_resume;
        logic [7:0] held;
        logic       tmo;
    } model_t;

    model_t mdl [2];  // [0] round-robin, [1] fixed priority

    function automatic model_t model_reset();
        return '{owner: 2'd0, parked: 2'd0, resume: 1'b0, last: 2'd2, in_resume: 1'b0,
                 held: 8'd0, tmo: 1'b0};
    endfunction

    function automatic logic [1:0] tie_winner(input int mode, input logic [1:0] last);
        if (mode == 0) return 2'd1;
        return (last == 2'd1) ? 2'd2 : 2'd1;
    endfunction

    function automatic model_t model_step(input model_t m, input int mode, input logic b1,
                                          input logic b2, input logic txd, input logic s3);
        model_t     n;
        logic [2:0] req;
        logic [1:0] x, y;
        logic       take, to, own_ok, oth_ok, e1, e2;
        n      = m;
        n.tmo  = 1'b0;
        req    = {b2, b1, 1'b0};
        if (m.parked != 2'd0 && !s3) n.resume = 1'b1;
        if (m.in_resume) begin
            n.in_resume = 1'b0;
            n.held      = 8'd1;
        end else if (m.owner == 2'd0) begin
            if (m.resume) begin
                n.in_resume = 1'b1; n.owner = m.parked; n.parked = 2'd0; n.resume = 1'b0;
                n.held = 8'd0;
            end else begin
                e1 = b1 && (m.parked != 2'd1);
                e2 = b2 && (m.parked != 2'd2);
                if (e1 && e2) n.owner = tie_winner(mode, m.last);
                else if (e1)  n.owner = 2'd1;
                else if (e2)  n.owner = 2'd2;
                n.held = (n.owner != 2'd0) ? 8'd1 : 8'd0;
            end
        end else begin
            x    = m.owner;
            y    = 2'd3 - x;
            take = s3 && (m.parked == 2'd0);
            to   = 1'b0;
`ifdef ARB_TIMEOUT_EN
            to   = (m.held == 8'(T)) && !txd && !take && req[x];
`endif
            if (take || txd || !req[x] || to) begin
                n.last = x;
                n.tmo  = to;
                if (take) n.parked = x;
                if (m.resume) begin
                    n.in_resume = 1'b1; n.owner = m.parked; n.parked = 2'd0; n.resume = 1'b0;
                    n.held = 8'd0;
                end else begin
                    own_ok = req[x] && !take && !to;
                    oth_ok = req[y] && (m.parked != y);
                    if (!oth_ok)     n.owner = 2'd0;
                    else if (own_ok) n.owner = tie_winner(mode, x);
                    else             n.owner = y;
                    n.held = (n.owner != 2'd0) ? 8'd1 : 8'd0;
                end
            end else begin
                n.held = m.held + 8'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [8:0] exp_vec(input model_t m);
        logic g1, g2;
        g1 = (m.owner == 2'd1);
        g2 = (m.owner == 2'd2);
        return {g1, g2, m.parked == 2'd1, m.parked == 2'd2, m.in_resume, g2, g1,
                g1 | g2 | m.in_resume, m.tmo};
    endfunction

    task automatic step();
        @(posedge clk);
        mdl[0] = model_step(mdl[0], 1, m1_breq, m2_breq, tx_done, s3_split);
        mdl[1] = model_step(mdl[1], 0, m1_breq, m2_breq, tx_done, s3_split);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        m1_breq = 1'b0; m2_breq = 1'b0; tx_done = 1'b0; s3_split = 1'b0;
        mdl[0] = model_reset();
        mdl[1] = model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        checks++;
        if (obs_rr !== 9'b0) begin
            errors++; $display("FAIL reset_rr got %b want %b", obs_rr, 9'b0);
        end
        checks++;
        if (obs_fp !== 9'b0) begin
            errors++; $display("FAIL reset_fp got %b want %b", obs_fp, 9'b0);
        end
        do_reset();
        repeat (2) begin
            step();
            checks++;
            if (obs_rr !== exp_vec(mdl[0])) begin
                errors++; $display("FAIL reset_idle_rr got %b want %b", obs_rr, exp_vec(mdl[0]));
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        m1_breq = 1'b1;
        step();
        checks++;
        if (rr_if.bus_sel !== 2'b01 || rr_if.m1_bgrant !== 1'b1) begin
            errors++; $display("FAIL single_grant got sel %b want 01", rr_if.bus_sel);
        end
        repeat (4) begin
            step();
            checks++;
            if (obs_fp !== exp_vec(mdl[1])) begin
                errors++; $display("FAIL single_hold_fp got %b want %b", obs_fp, exp_vec(mdl[1]));
            end
        end
        tx_done = 1'b1; m1_breq = 1'b0;
        step();
        tx_done = 1'b0;
        checks++;
        if (rr_if.bus_sel !== 2'b00 || rr_if.bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release got sel %b busy %b want 00 0", rr_if.bus_sel,
                     rr_if.bus_busy);
        end
    endtask

    task automatic test_tie();
        do_reset();
        m1_breq = 1'b1; m2_breq = 1'b1;
        step();
        checks++;
        if (rr_if.bus_sel !== 2'b01 || fp_if.bus_sel !== 2'b01) begin
            errors++;
            $display("FAIL tie_first got rr %b fp %b want 01 01", rr_if.bus_sel, fp_if.bus_sel);
        end
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (rr_if.bus_sel !== 2'b10) begin
            errors++; $display("FAIL tie_rr_handoff got %b want 10", rr_if.bus_sel);
        end
        checks++;
        if (fp_if.bus_sel !== 2'b01) begin
            errors++; $display("FAIL tie_fp_keep got %b want 01", fp_if.bus_sel);
        end
        m1_breq = 1'b0; m2_breq = 1'b0; tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (obs_rr !== exp_vec(mdl[0])) begin
            errors++; $display("FAIL tie_end_rr got %b want %b", obs_rr, exp_vec(mdl[0]));
        end
    endtask

    task automatic test_split();
        do_reset();
        m1_breq = 1'b1;
        step();
        m2_breq = 1'b1; s3_split = 1'b1;
        step();
        checks++;
        if (rr_if.m1_split !== 1'b1 || rr_if.m1_bgrant !== 1'b0 || rr_if.m2_bgrant !== 1'b1) begin
            errors++;
            $display("FAIL split_park got split %b g1 %b g2 %b want 1 0 1", rr_if.m1_split,
                     rr_if.m1_bgrant, rr_if.m2_bgrant);
        end
        step();
        s3_split = 1'b0;
        step();
        step();
        checks++;
        if (obs_fp !== exp_vec(mdl[1])) begin
            errors++; $display("FAIL split_wait_fp got %b want %b", obs_fp, exp_vec(mdl[1]));
        end
        tx_done = 1'b1; m2_breq = 1'b0;
        step();
        tx_done = 1'b0;
        checks++;
        if (rr_if.s3_split_grant !== 1'b1 || rr_if.m1_bgrant !== 1'b1 ||
            rr_if.m1_split !== 1'b0) begin
            errors++;
            $display("FAIL split_resume got sg %b g1 %b sp %b want 1 1 0", rr_if.s3_split_grant,
                     rr_if.m1_bgrant, rr_if.m1_split);
        end
        step();
        checks++;
        if (obs_rr !== exp_vec(mdl[0]) || rr_if.m1_bgrant !== 1'b1) begin
            errors++; $display("FAIL split_after_rr got %b want %b", obs_rr, exp_vec(mdl[0]));
        end
        m1_breq = 1'b0; tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        m1_breq = 1'b1;
        step();
        m2_breq = 1'b1; tx_done = 1'b1; s3_split = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (rr_if.m1_split !== 1'b1 || rr_if.m2_bgrant !== 1'b1) begin
            errors++;
            $display("FAIL simul_split got sp %b g2 %b want 1 1", rr_if.m1_split, rr_if.m2_bgrant);
        end
        s3_split = 1'b0;
        step();
        s3_split = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_rr !== exp_vec(mdl[0]) || rr_if.m2_split !== 1'b0) begin
                errors++; $display("FAIL simul_second_rr got %b want %b", obs_rr, exp_vec(mdl[0]));
            end
            checks++;
            if (obs_fp !== exp_vec(mdl[1])) begin
                errors++; $display("FAIL simul_second_fp got %b want %b", obs_fp, exp_vec(mdl[1]));
            end
        end
        s3_split = 1'b0; m2_breq = 1'b0; tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        m1_breq = 1'b0; tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_breq = 1'b1;
        step();
        m2_breq = 1'b1; s3_split = 1'b1;
        step();
        step();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (obs_rr !== 9'b0 || obs_fp !== 9'b0) begin
            errors++; $display("FAIL reset_mid got rr %b fp %b want 0", obs_rr, obs_fp);
        end
        m1_breq = 1'b0; m2_breq = 1'b0; s3_split = 1'b0;
        mdl[0] = model_reset();
        mdl[1] = model_reset();
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (obs_rr !== 9'b0 || obs_fp !== exp_vec(mdl[1])) begin
                errors++; $display("FAIL reset_mid_idle got rr %b fp %b want 0", obs_rr, obs_fp);
            end
        end
    endtask

    task automatic test_timeout();
        int owned;
        do_reset();
        m1_breq = 1'b1;
        owned = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rr_if.m1_bgrant === 1'b1 && owned == i) owned++;
            checks++;
            if (obs_rr !== exp_vec(mdl[0])) begin
                errors++; $display("FAIL timeout_rr got %b want %b", obs_rr, exp_vec(mdl[0]));
            end
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (owned != int'(T)) begin
            errors++; $display("FAIL timeout_len got %0d want %0d", owned, T);
        end
`else
        checks++;
        if (owned != 12 || rr_if.timeout !== 1'b0) begin
            errors++; $display("FAIL no_timeout_hold got %0d want 12", owned);
        end
`endif
        m1_breq = 1'b0;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) m1_breq = ~m1_breq;
            if ($urandom_range(7) == 0) m2_breq = ~m2_breq;
            if ($urandom_range(9) == 0) s3_split = ~s3_split;
            tx_done = ($urandom_range(5) == 0);
            step();
            checks++;
            if (obs_rr !== exp_vec(mdl[0])) begin
                errors++;
                $display("FAIL random_rr cyc %0d got %b want %b", i, obs_rr, exp_vec(mdl[0]));
            end
            checks++;
            if (obs_fp !== exp_vec(mdl[1])) begin
                errors++;
                $display("FAIL random_fp cyc %0d got %b want %b", i, obs_fp, exp_vec(mdl[1]));
            end
        end
        tx_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mdl[0] = model_reset();
        mdl[1] = model_reset();
        test_reset();
        test_single();
        test_tie();
        test_split();
        test_simultaneous();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
